// File: rtl/needs_engine_pkg.sv
// tama_pkg: definitions shared by the needs engine and the status block.
//   - action codes carried on action_code
//   - life-state encoding (ALIVE / SLEEPING / DEAD)
//   - default saturation ceiling and critical threshold
//   - status vector value that signals death
package tama_pkg;

    localparam int LEVEL_W       = 5;
    localparam int DEF_LEVEL_MAX = 15;
    localparam int DEF_THRESH    = 12;

    localparam logic [7:0] STATUS_DEAD = 8'hFF;

    localparam logic [2:0] ACT_NOP    = 3'd0;
    localparam logic [2:0] ACT_FEED   = 3'd1;
    localparam logic [2:0] ACT_PLAY   = 3'd2;
    localparam logic [2:0] ACT_CLEAN  = 3'd3;
    localparam logic [2:0] ACT_HEAL   = 3'd4;
    localparam logic [2:0] ACT_SLEEP  = 3'd5;
    localparam logic [2:0] ACT_WAKE   = 3'd6;
    localparam logic [2:0] ACT_SOCIAL = 3'd7;

    typedef enum logic [1:0] {
        ALIVE    = 2'd0,
        SLEEPING = 2'd1,
        DEAD     = 2'd2
    } life_state_e;

endpackage

// File: rtl/needs_engine_if.sv
// needs_engine_if: player-action handshake.
//   action_valid / action_code : request from the player side
//   action_ready               : engine can accept this cycle
//   action_done / action_rej   : one-cycle result pulses after an accept
// master = requester, slave = needs_engine.
interface needs_engine_if;
    logic       action_valid;
    logic [2:0] action_code;
    logic       action_ready;
    logic       action_done;
    logic       action_rej;

    modport master (
        output action_valid, action_code,
        input  action_ready, action_done, action_rej
    );

    modport slave (
        input  action_valid, action_code,
        output action_ready, action_done, action_rej
    );
endinterface

// File: rtl/needs_engine_need_counter.sv
// need_counter: one need level with its game-tick prescaler.
//   clk, reset : clock, synchronous active-high reset
//   tick       : game-time strobe
//   inc_en     : prescaler counts on tick only while high (holds otherwise)
//   hold       : freezes prescaler and level completely
//   dec_amt    : amount subtracted this cycle (floors at 0)
//   add_amt    : extra amount added this cycle on top of the prescaler increment
//   level      : registered level, 0..LEVEL_MAX
module need_counter #(
    parameter int DIV       = 4,
    parameter int LEVEL_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       inc_en,
    input  logic       hold,
    input  logic [4:0] dec_amt,
    input  logic [4:0] add_amt,
    output logic [4:0] level
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    level_q, level_d;
    logic [4:0]    sub;
    logic [5:0]    sum;
    logic          inc;

    always_comb begin
        cnt_d = cnt_q;
        inc   = 1'b0;
        if (tick && inc_en) begin
            if (cnt_q == CW'(DIV - 1)) begin
                cnt_d = '0;
                inc   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Subtract first, then add, so a same-cycle action and increment never wrap.
        sub     = (level_q > dec_amt) ? (level_q - dec_amt) : '0;
        sum     = {1'b0, sub} + {1'b0, add_amt} + {5'd0, inc};
        level_d = (sum > 6'(LEVEL_MAX)) ? 5'(LEVEL_MAX) : sum[4:0];
        if (hold) begin
            cnt_d   = cnt_q;
            level_d = level_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
endmodule

// File: rtl/needs_engine.sv
// needs_engine: owns the six need levels, the action handshake, the action
// cooldown, the age counter and the ALIVE/SLEEPING/DEAD life state.
//   clk, reset  : clock, synchronous active-high reset
//   tick        : one-cycle game-time strobe
//   act         : action handshake (slave side)
//   status_in   : status vector fed back from the status block (8'hFF = dead)
//   hunger..social : registered need levels (higher = worse)
//   sleeping, dead : life state flags
//   age         : ticks lived, saturating
module needs_engine
    import tama_pkg::*;
#(
    parameter int LEVEL_MAX   = DEF_LEVEL_MAX,
    parameter int THRESH      = DEF_THRESH,
    parameter int HUNGER_DIV  = 4,
    parameter int HAPPY_DIV   = 6,
    parameter int HYGIENE_DIV = 8,
    parameter int SOCIAL_DIV  = 10,
    parameter int ENERGY_DIV  = 5,
    parameter int HEALTH_DIV  = 3,
    parameter int RELIEF      = 6,
    parameter int COOLDOWN    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    needs_engine_if.slave act,
    input  logic [7:0]  status_in,
    output logic [4:0]  hunger,
    output logic [4:0]  happiness,
    output logic [4:0]  health,
    output logic [4:0]  hygiene,
    output logic [4:0]  energy,
    output logic [4:0]  social,
    output logic        sleeping,
    output logic        dead,
    output logic [15:0] age
);
    localparam logic [4:0] RELIEF_V = 5'(RELIEF);

    life_state_e state_q, state_d;
    logic [7:0]  cooldown_q, cooldown_d;
    logic [15:0] age_q, age_d;
    logic        done_q, done_d, rej_q, rej_d;

    logic die, frozen, ready, take, applied;
    logic [4:0] dec_hunger, dec_happy, dec_health, dec_hygiene, dec_energy, dec_social;
    logic [4:0] add_energy;

    // A dying cycle freezes everything, so an action or tick coinciding with
    // the death condition has no effect and produces no result pulse.
    assign die    = (state_q != DEAD) &&
                    ((hunger == 5'(LEVEL_MAX)) || (health == 5'(LEVEL_MAX)) ||
                     (status_in == STATUS_DEAD));
    assign frozen = (state_q == DEAD) || die;
    assign ready  = (state_q != DEAD) && (cooldown_q == '0);
    assign take   = act.action_valid && ready && !frozen;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ALIVE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ALIVE: begin
                if (die)                                     state_d = DEAD;
                else if (take && act.action_code == ACT_SLEEP) state_d = SLEEPING;
            end
            SLEEPING: begin
                if (die) state_d = DEAD;
                else if ((take && act.action_code == ACT_WAKE) || energy == '0)
                    state_d = ALIVE;
            end
            default: state_d = DEAD;
        endcase
    end

    // Output / action-effect logic
    always_comb begin
        applied     = 1'b0;
        dec_hunger  = '0;
        dec_happy   = '0;
        dec_health  = '0;
        dec_hygiene = '0;
        dec_social  = '0;
        dec_energy  = '0;
        add_energy  = '0;
        if (state_q == SLEEPING && tick) dec_energy = 5'd1;
        if (take) begin
            unique case (state_q)
                ALIVE: begin
                    case (act.action_code)
                        ACT_FEED:   begin dec_hunger  = RELIEF_V; applied = 1'b1; end
                        ACT_PLAY:   begin
                            dec_happy  = RELIEF_V;
                            dec_social = 5'd2;
                            add_energy = 5'd2;
                            applied    = 1'b1;
                        end
                        ACT_CLEAN:  begin dec_hygiene = RELIEF_V; applied = 1'b1; end
                        ACT_HEAL:   begin dec_health  = RELIEF_V; applied = 1'b1; end
                        ACT_SOCIAL: begin dec_social  = RELIEF_V; applied = 1'b1; end
                        ACT_SLEEP:  applied = 1'b1;
                        default:    applied = 1'b0;
                    endcase
                end
                SLEEPING: applied = (act.action_code == ACT_WAKE);
                default:  applied = 1'b0;
            endcase
        end
        done_d = take && applied;
        rej_d  = take && !applied;
    end

    always_comb begin
        cooldown_d = cooldown_q;
        if (take)                                     cooldown_d = 8'(COOLDOWN);
        else if (tick && !frozen && cooldown_q != '0) cooldown_d = cooldown_q - 8'd1;
        age_d = age_q;
        if (tick && !frozen && age_q != '1) age_d = age_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cooldown_q <= '0;
            age_q      <= '0;
            done_q     <= 1'b0;
            rej_q      <= 1'b0;
        end else begin
            cooldown_q <= cooldown_d;
            age_q      <= age_d;
            done_q     <= done_d;
            rej_q      <= rej_d;
        end
    end

    need_counter #(.DIV(HUNGER_DIV), .LEVEL_MAX(LEVEL_MAX)) u_hunger (
        .clk(clk), .reset(reset), .tick(tick), .inc_en(1'b1), .hold(frozen),
        .dec_amt(dec_hunger), .add_amt(5'd0), .level(hunger));
    need_counter #(.DIV(HAPPY_DIV), .LEVEL_MAX(LEVEL_MAX)) u_happy (
        .clk(clk), .reset(reset), .tick(tick), .inc_en(1'b1), .hold(frozen),
        .dec_amt(dec_happy), .add_amt(5'd0), .level(happiness));
    need_counter #(.DIV(HEALTH_DIV), .LEVEL_MAX(LEVEL_MAX)) u_health (
        .clk(clk), .reset(reset), .tick(tick),
        .inc_en((hunger >= 5'(THRESH)) || (hygiene >= 5'(THRESH))), .hold(frozen),
        .dec_amt(dec_health), .add_amt(5'd0), .level(health));
    need_counter #(.DIV(HYGIENE_DIV), .LEVEL_MAX(LEVEL_MAX)) u_hygiene (
        .clk(clk), .reset(reset), .tick(tick), .inc_en(1'b1), .hold(frozen),
        .dec_amt(dec_hygiene), .add_amt(5'd0), .level(hygiene));
    need_counter #(.DIV(ENERGY_DIV), .LEVEL_MAX(LEVEL_MAX)) u_energy (
        .clk(clk), .reset(reset), .tick(tick), .inc_en(state_q == ALIVE), .hold(frozen),
        .dec_amt(dec_energy), .add_amt(add_energy), .level(energy));
    need_counter #(.DIV(SOCIAL_DIV), .LEVEL_MAX(LEVEL_MAX)) u_social (
        .clk(clk), .reset(reset), .tick(tick), .inc_en(1'b1), .hold(frozen),
        .dec_amt(dec_social), .add_amt(5'd0), .level(social));

    assign act.action_ready = ready;
    assign act.action_done  = done_q;
    assign act.action_rej   = rej_q;
    assign sleeping         = (state_q == SLEEPING);
    assign dead             = (state_q == DEAD);
    assign age              = age_q;
endmodule
